regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 108 ++++++++++
 tb/tb_regfile_sb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register pending-write scoreboard.
// Two combinational read ports, one write port, one reservation port and a
// registered count of pending registers. Register 0 is hardwired to zero.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on both read ports. State registers are identical either way.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic [AW-1:0]   rd,
    input  logic            enable,
    input  logic [XLEN-1:0] data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_rd,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      cnt_next;
    logic             write_hit;
    logic             rsv_hit;

    assign write_hit = enable && (rd != '0);
    assign rsv_hit   = rsv_en && (rsv_rd != '0);

    // Next busy vector: a reservation wins over a clearing write; bit 0 never sets.
    always_comb begin
        busy_next = '0;
        for (int i = 1; i < NREGS; i++) begin
            busy_next[i] = (rsv_hit && (rsv_rd == AW'(i)))
                         || (busy[i] && !(write_hit && (rd == AW'(i))));
        end
    end

    // Population count of the next busy vector, so busy_cnt tracks it on the same edge.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    // Register storage; index 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[rd] <= data;
        end
    end

    // Scoreboard bits and their registered population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    // Read port 1: stored value and busy bit, forced to zero while in reset.
    always_comb begin
        rs1_out  = '0;
        rs1_busy = 1'b0;
        if (rst_n) begin
            rs1_out  = regs[rs1];
            rs1_busy = busy[rs1];
`ifdef REGFILE_BYPASS_EN
            if (write_hit && (rd == rs1)) begin
                rs1_out  = data;
                rs1_busy = rsv_en && (rsv_rd == rs1);
            end
`endif
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        rs2_out  = '0;
        rs2_busy = 1'b0;
        if (rst_n) begin
            rs2_out  = regs[rs2];
            rs2_busy = busy[rs2];
`ifdef REGFILE_BYPASS_EN
            if (write_hit && (rd == rs2)) begin
                rs2_out  = data;
                rs2_busy = rsv_en && (rsv_rd == rs2);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb with a behavioural register/scoreboard model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1, rs2, rd, rsv_rd;
    logic [XLEN-1:0] rs1_out, rs2_out, data;
    logic            rs1_busy, rs2_busy, enable, rsv_en;
    logic [AW:0]     busy_cnt;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1(rs1), .rs2(rs2),
        .rs1_out(rs1_out), .rs2_out(rs2_out),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd(rd), .enable(enable), .data(data),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one clock edge: write clears, then reservation sets (so set wins).
    task automatic model_clock();
        if (enable && rd != 0) begin
            m_regs[rd] = data;
            m_busy[rd] = 1'b0;
        end
        if (rsv_en && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
    endtask

    function automatic int m_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [XLEN-1:0] exp_out(input logic [AW-1:0] idx);
        if (!rst_n || idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (enable && rd == idx) return data;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] idx);
        if (!rst_n || idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (enable && rd == idx) return rsv_en && rsv_rd == idx;
`endif
        return m_busy[idx];
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input logic en, input logic [AW-1:0] w_rd, input logic [XLEN-1:0] w_data,
                         input logic r_en, input logic [AW-1:0] r_rd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        enable = en; rd = w_rd; data = w_data;
        rsv_en = r_en; rsv_rd = r_rd;
        rs1 = a1; rs2 = a2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        enable = 1'b1; rd = 5; data = 32'hCAFEF00D;
        rsv_en = 1'b1; rsv_rd = 5; rs1 = 5; rs2 = 31;
        #3;
        checks++; if (rs1_out !== 32'h0) begin errors++; $display("FAIL reset_rs1_out got %h exp 0", rs1_out); end
        checks++; if (rs2_out !== 32'h0) begin errors++; $display("FAIL reset_rs2_out got %h exp 0", rs2_out); end
        checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL reset_busy_cnt got %0d exp 0", busy_cnt); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy got %b exp 0", rs1_busy); end
        @(posedge clk); #1;
        checks++; if (rs1_out !== 32'h0 || busy_cnt !== '0) begin errors++; $display("FAIL reset_held got %h/%0d exp 0/0", rs1_out, busy_cnt); end
        @(negedge clk);
        enable = 1'b0; rsv_en = 1'b0; rd = 0; rsv_rd = 0; data = '0;
        rst_n = 1'b1;
        #1;
        checks++; if (rs1_out !== 32'h0 || rs2_out !== 32'h0) begin errors++; $display("FAIL release_reads got %h %h exp 0 0", rs1_out, rs2_out); end
        tick();
        checks++; if (busy_cnt !== '0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL release_busy got %0d %b exp 0 0", busy_cnt, rs1_busy); end
    endtask

    task automatic test_write_x0();
        drive(1'b1, 0, 32'hDEADBEEF, 1'b1, 0, 0, 0);
        checks++; if (rs1_out !== 32'h0) begin errors++; $display("FAIL x0_same_cycle got %h exp 0", rs1_out); end
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 0, '0, 1'b0, 0, 0, 0);
            checks++; if (rs1_out !== 32'h0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_read cycle %0d got %h %b exp 0 0", c, rs1_out, rs1_busy); end
            tick();
        end
        checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL x0_busy_cnt got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_write_read();
        logic [XLEN-1:0] exp_wc;
`ifdef REGFILE_BYPASS_EN
        exp_wc = 32'h12345678;
`else
        exp_wc = 32'h0;
`endif
        drive(1'b1, 7, 32'h12345678, 1'b0, 0, 7, 7);
        checks++; if (rs1_out !== exp_wc) begin errors++; $display("FAIL wr_same_cycle got %h exp %h", rs1_out, exp_wc); end
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 7, 0);
        checks++; if (rs1_out !== 32'h12345678) begin errors++; $display("FAIL wr_next_cycle got %h exp 12345678", rs1_out); end
    endtask

    task automatic test_scoreboard();
        logic exp_wb;
`ifdef REGFILE_BYPASS_EN
        exp_wb = 1'b0;
`else
        exp_wb = 1'b1;
`endif
        drive(1'b0, 0, '0, 1'b1, 3, 0, 3);
        checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_rsv_cycle got %b exp 0", rs2_busy); end
        tick();
        checks++; if (rs2_busy !== 1'b1 || busy_cnt !== 1) begin errors++; $display("FAIL sb_reserved got %b %0d exp 1 1", rs2_busy, busy_cnt); end
        drive(1'b0, 0, '0, 1'b1, 3, 0, 3);
        tick();
        checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL sb_no_double got %0d exp 1", busy_cnt); end
        drive(1'b1, 3, 32'h0BADF00D, 1'b0, 0, 0, 3);
        checks++; if (rs2_busy !== exp_wb) begin errors++; $display("FAIL sb_write_cycle got %b exp %b", rs2_busy, exp_wb); end
        tick();
        checks++; if (rs2_busy !== 1'b0 || busy_cnt !== 0) begin errors++; $display("FAIL sb_cleared got %b %0d exp 0 0", rs2_busy, busy_cnt); end
        drive(1'b1, 11, 32'h11111111, 1'b1, 12, 11, 12);
        tick();
        checks++; if (rs1_out !== 32'h11111111 || rs1_busy !== 1'b0 || rs2_busy !== 1'b1 || busy_cnt !== 1)
            begin errors++; $display("FAIL sb_diff_idx got %h %b %b %0d exp 11111111 0 1 1", rs1_out, rs1_busy, rs2_busy, busy_cnt); end
        drive(1'b1, 12, 32'h22222222, 1'b0, 0, 0, 0);
        tick();
    endtask

    task automatic test_collision();
        logic [XLEN-1:0] exp_wc;
`ifdef REGFILE_BYPASS_EN
        exp_wc = 32'hA5A5A5A5;
`else
        exp_wc = 32'h0;
`endif
        drive(1'b0, 0, '0, 1'b1, 9, 0, 0);
        tick();
        checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL col_pre got %0d exp 1", busy_cnt); end
        drive(1'b1, 9, 32'hA5A5A5A5, 1'b1, 9, 9, 9);
        checks++; if (rs1_out !== exp_wc || rs1_busy !== 1'b1) begin errors++; $display("FAIL col_same_cycle got %h %b exp %h 1", rs1_out, rs1_busy, exp_wc); end
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 9, 9);
        checks++; if (rs1_out !== 32'hA5A5A5A5 || rs2_busy !== 1'b1 || busy_cnt !== 1)
            begin errors++; $display("FAIL col_after got %h %b %0d exp a5a5a5a5 1 1", rs1_out, rs2_busy, busy_cnt); end
        drive(1'b1, 9, 32'hA5A5A5A5, 1'b0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] a1, a2, w, r;
        for (int c = 0; c < 400; c++) begin
            w  = AW'($urandom_range(0, NREGS - 1));
            r  = ($urandom_range(0, 3) == 0) ? w : AW'($urandom_range(0, NREGS - 1));
            a1 = ($urandom_range(0, 2) == 0) ? w : AW'($urandom_range(0, NREGS - 1));
            a2 = ($urandom_range(0, 2) == 0) ? r : AW'($urandom_range(0, NREGS - 1));
            drive(1'($urandom_range(0, 1)), w, $urandom, 1'($urandom_range(0, 4) < 2), r, a1, a2);
            checks++; if (rs1_out !== exp_out(rs1)) begin errors++; $display("FAIL rand_rs1_out c%0d got %h exp %h", c, rs1_out, exp_out(rs1)); end
            checks++; if (rs2_out !== exp_out(rs2)) begin errors++; $display("FAIL rand_rs2_out c%0d got %h exp %h", c, rs2_out, exp_out(rs2)); end
            checks++; if (rs1_busy !== exp_busy(rs1)) begin errors++; $display("FAIL rand_rs1_busy c%0d got %b exp %b", c, rs1_busy, exp_busy(rs1)); end
            checks++; if (rs2_busy !== exp_busy(rs2)) begin errors++; $display("FAIL rand_rs2_busy c%0d got %b exp %b", c, rs2_busy, exp_busy(rs2)); end
            tick();
            checks++; if (int'(busy_cnt) != m_count()) begin errors++; $display("FAIL rand_busy_cnt c%0d got %0d exp %0d", c, busy_cnt, m_count()); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2, 32'h0000_0002, 1'b0, 0, 0, 0);
        tick();
        // clear whatever the random phase left busy
        for (int i = 1; i < NREGS; i++) begin
            drive(1'b1, AW'(i), 32'(i * 3), 1'b0, 0, 0, 0);
            tick();
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 0, '0, 1'b1, AW'(i), 0, 0);
            tick();
        end
        checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL ar_pre_cnt got %0d exp 4", busy_cnt); end
        drive(1'b1, 1, 32'h77777777, 1'b1, 6, 1, 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", busy_cnt); end
        checks++; if (rs1_out !== 0 || rs2_out !== 0 || rs1_busy !== 0 || rs2_busy !== 0)
            begin errors++; $display("FAIL ar_reads got %h %h %b %b exp 0 0 0 0", rs1_out, rs2_out, rs1_busy, rs2_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0; rsv_en = 1'b0;
        #1;
        checks++; if (rs1_out !== 0 || rs2_out !== 0 || rs2_busy !== 0 || busy_cnt !== 0)
            begin errors++; $display("FAIL ar_discard got %h %h %b %0d exp 0 0 0 0", rs1_out, rs2_out, rs2_busy, busy_cnt); end
        drive(1'b1, 4, 32'h44444444, 1'b1, 6, 4, 6);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 4, 6);
        checks++; if (rs1_out !== 32'h44444444 || rs2_busy !== 1'b1 || busy_cnt !== 1)
            begin errors++; $display("FAIL ar_first_after got %h %b %0d exp 44444444 1 1", rs1_out, rs2_busy, busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_x0();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
